// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Y86-64 execute stage. Takes the e_* fields of the D->E pipeline
//            register, computes the ALU result, owns the condition-code
//            register {ZF,SF,OF}, evaluates the branch/cmov condition and
//            registers everything into the E->M pipeline register (m_*).
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            e_icode/e_ifun        - instruction / function code
//            e_regA/e_regB         - register specifier fields
//            e_valC/e_valP         - constant word / next PC
//            e_valA/e_valB         - forwarded operands
//            cc_block              - suppress CC write (exception downstream)
//            m_stall/m_bubble      - E->M register hold / nop insertion
//            m_icode..m_dstM       - E->M pipeline register contents
//            cc_out                - current CC {ZF,SF,OF}
// Config   : EXECUTE_FWD_EN - when defined, adds e_valE_fwd / e_dstE_fwd,
//            the combinational valE / dstE of the current cycle, so decode
//            can forward without waiting for the E->M register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RRSP  = 4'h4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [3:0]   e_regA,
    input  logic [3:0]   e_regB,
    input  logic [W-1:0] e_valC,
    input  logic [W-1:0] e_valP,
    input  logic [W-1:0] e_valA,
    input  logic [W-1:0] e_valB,
    input  logic         cc_block,
    input  logic         m_stall,
    input  logic         m_bubble,
    output logic [3:0]   m_icode,
    output logic         m_cnd,
    output logic [W-1:0] m_valE,
    output logic [W-1:0] m_valA,
    output logic [W-1:0] m_valP,
    output logic [3:0]   m_dstE,
    output logic [3:0]   m_dstM,
`ifdef EXECUTE_FWD_EN
    output logic [W-1:0] e_valE_fwd,
    output logic [3:0]   e_dstE_fwd,
`endif
    output logic [2:0]   cc_out
);

    // Instruction codes
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    // ALU functions
    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_AND = 2'd2;
    localparam logic [1:0] c_ALU_XOR = 2'd3;

    // Stack pointer adjustments, as full-width two's complement words
    localparam logic [W-1:0] c_MINUS8 = {{(W-4){1'b1}}, 4'h8};
    localparam logic [W-1:0] c_PLUS8  = {{(W-4){1'b0}}, 4'h8};

    localparam logic [2:0] c_CC_RESET = 3'b100;

    logic [W-1:0] w_alu_a;
    logic [W-1:0] w_alu_b;
    logic [1:0]   w_alu_fun;
    logic [W-1:0] w_val_e;
    logic         w_of;
    logic         w_zf;
    logic         w_sf;
    logic         w_lt;
    logic         w_cond;
    logic         w_cnd;
    logic [3:0]   w_dst_e;
    logic [3:0]   w_dst_m;
    logic         w_cc_load;
    logic [2:0]   r_cc;

    // ALU operand A
    always_comb begin
        w_alu_a = '0;
        case (e_icode)
            c_I_RRMOVQ, c_I_OPQ:                  w_alu_a = e_valA;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ:   w_alu_a = e_valC;
            c_I_CALL, c_I_PUSHQ:                  w_alu_a = c_MINUS8;
            c_I_RET, c_I_POPQ:                    w_alu_a = c_PLUS8;
            default:                              w_alu_a = '0;
        endcase
    end

    // ALU operand B
    always_comb begin
        w_alu_b = '0;
        case (e_icode)
            c_I_RMMOVQ, c_I_MRMOVQ, c_I_OPQ, c_I_CALL,
            c_I_RET, c_I_PUSHQ, c_I_POPQ:         w_alu_b = e_valB;
            default:                              w_alu_b = '0;
        endcase
    end

    // Only OPq selects its own function; undefined OPq ifun values fall back to add
    assign w_alu_fun = (e_icode == c_I_OPQ && e_ifun[3:2] == 2'b00) ? e_ifun[1:0] : c_ALU_ADD;

    // ALU and overflow detection. Subtraction is B - A, so overflow is judged
    // against the sign of B (the minuend).
    always_comb begin
        w_val_e = '0;
        w_of    = 1'b0;
        case (w_alu_fun)
            c_ALU_ADD: begin
                w_val_e = w_alu_b + w_alu_a;
                w_of    = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_val_e[W-1] != w_alu_a[W-1]);
            end
            c_ALU_SUB: begin
                w_val_e = w_alu_b - w_alu_a;
                w_of    = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_val_e[W-1] != w_alu_b[W-1]);
            end
            c_ALU_AND: w_val_e = w_alu_a & w_alu_b;
            c_ALU_XOR: w_val_e = w_alu_a ^ w_alu_b;
            default:   w_val_e = '0;
        endcase
    end

    assign w_zf = (w_val_e == '0);
    assign w_sf = w_val_e[W-1];

    // Condition evaluation uses the committed CC, i.e. the flags of the
    // previous OPq, never those being produced this cycle.
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cond = 1'b0;
        case (e_ifun)
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = w_lt | r_cc[2];
            4'd2:    w_cond = w_lt;
            4'd3:    w_cond = r_cc[2];
            4'd4:    w_cond = ~r_cc[2];
            4'd5:    w_cond = ~w_lt;
            4'd6:    w_cond = ~w_lt & ~r_cc[2];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd = (e_icode == c_I_RRMOVQ || e_icode == c_I_JXX) ? w_cond : 1'b0;

    // Destination selection; a failed cmov writes nothing
    always_comb begin
        w_dst_e = RNONE;
        case (e_icode)
            c_I_RRMOVQ:                              w_dst_e = w_cnd ? e_regB : RNONE;
            c_I_IRMOVQ, c_I_OPQ:                     w_dst_e = e_regB;
            c_I_CALL, c_I_RET, c_I_PUSHQ, c_I_POPQ:  w_dst_e = RRSP;
            default:                                 w_dst_e = RNONE;
        endcase
    end

    always_comb begin
        w_dst_m = RNONE;
        case (e_icode)
            c_I_MRMOVQ, c_I_POPQ: w_dst_m = e_regA;
            default:              w_dst_m = RNONE;
        endcase
    end

    // CC update is independent of stall/bubble on the E->M register
    assign w_cc_load = (e_icode == c_I_OPQ) && !cc_block;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cc <= c_CC_RESET;
        end else if (w_cc_load) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    assign cc_out = r_cc;

    // E->M pipeline register: reset and bubble both load a nop
    always_ff @(posedge clock) begin
        if (reset || m_bubble) begin
            m_icode <= c_I_NOP;
            m_cnd   <= 1'b0;
            m_valE  <= '0;
            m_valA  <= '0;
            m_valP  <= '0;
            m_dstE  <= RNONE;
            m_dstM  <= RNONE;
        end else if (!m_stall) begin
            m_icode <= e_icode;
            m_cnd   <= w_cnd;
            m_valE  <= w_val_e;
            m_valA  <= e_valA;
            m_valP  <= e_valP;
            m_dstE  <= w_dst_e;
            m_dstM  <= w_dst_m;
        end
    end

`ifdef EXECUTE_FWD_EN
    assign e_valE_fwd = w_val_e;
    assign e_dstE_fwd = w_dst_e;
`endif

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Self-checking bench for execute_stage. A table of directed
//            vectors (with hand-computed expected values) covers the named
//            corner cases, then randomized instructions are checked against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  e_icode, e_ifun, e_regA, e_regB;
    logic [63:0] e_valC, e_valP, e_valA, e_valB;
    logic        cc_block, m_stall, m_bubble;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE, m_valA, m_valP;
    logic [3:0]  m_dstE, m_dstM;
    logic [2:0]  cc_out;
`ifdef EXECUTE_FWD_EN
    logic [63:0] e_valE_fwd;
    logic [3:0]  e_dstE_fwd;
`endif

    always #5 clock = ~clock;

    execute_stage #(.W(64), .RNONE(4'hF), .RRSP(4'h4)) dut (
        .clock    (clock),
        .reset    (reset),
        .e_icode  (e_icode),
        .e_ifun   (e_ifun),
        .e_regA   (e_regA),
        .e_regB   (e_regB),
        .e_valC   (e_valC),
        .e_valP   (e_valP),
        .e_valA   (e_valA),
        .e_valB   (e_valB),
        .cc_block (cc_block),
        .m_stall  (m_stall),
        .m_bubble (m_bubble),
        .m_icode  (m_icode),
        .m_cnd    (m_cnd),
        .m_valE   (m_valE),
        .m_valA   (m_valA),
        .m_valP   (m_valP),
        .m_dstE   (m_dstE),
        .m_dstM   (m_dstM),
`ifdef EXECUTE_FWD_EN
        .e_valE_fwd (e_valE_fwd),
        .e_dstE_fwd (e_dstE_fwd),
`endif
        .cc_out   (cc_out)
    );

    typedef struct {
        logic        rst, blk, stall, bub;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, va, vb;
        logic [3:0]  x_ic;
        logic        x_cnd;
        logic [63:0] x_ve, x_va;
        logic [3:0]  x_de, x_dm;
        logic [2:0]  x_cc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, blk, stall, bub,
                                input logic [3:0] ic, fn, ra, rb,
                                input logic [63:0] vc, va, vb,
                                input logic [3:0] x_ic, input logic x_cnd,
                                input logic [63:0] x_ve, x_va,
                                input logic [3:0] x_de, x_dm, input logic [2:0] x_cc);
        vec_t v;
        v.rst = rst; v.blk = blk; v.stall = stall; v.bub = bub;
        v.ic = ic; v.fn = fn; v.ra = ra; v.rb = rb;
        v.vc = vc; v.va = va; v.vb = vb;
        v.x_ic = x_ic; v.x_cnd = x_cnd; v.x_ve = x_ve; v.x_va = x_va;
        v.x_de = x_de; v.x_dm = x_dm; v.x_cc = x_cc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [207:0] act, input logic [207:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: Y86 execute semantics computed with wide arithmetic.
    // Overflow is detected by doing the operation one bit wider on
    // sign-extended operands and seeing whether the top two bits disagree.
    task automatic ref_exec(input logic [3:0] ic, fn, ra, rb,
                            input logic [63:0] vc, va, vb,
                            input logic [2:0] cc,
                            output logic [63:0] ve, output logic cd,
                            output logic [3:0] de, dm, output logic [2:0] ccn);
        logic [64:0] wide;
        logic        of, cz, cs, co;
        of = 1'b0;
        ve = '0;
        case (ic)
            4'h2: ve = va;
            4'h3: ve = vc;
            4'h4, 4'h5: ve = vb + vc;
            4'h6: begin
                case (fn)
                    4'h1: begin
                        wide = {vb[63], vb} - {va[63], va};
                        ve = wide[63:0]; of = wide[64] != wide[63];
                    end
                    4'h2: ve = va & vb;
                    4'h3: ve = va ^ vb;
                    default: begin
                        wide = {vb[63], vb} + {va[63], va};
                        ve = wide[63:0]; of = wide[64] != wide[63];
                    end
                endcase
            end
            4'h8, 4'hA: ve = vb - 64'd8;
            4'h9, 4'hB: ve = vb + 64'd8;
            default: ve = '0;
        endcase
        ccn = (ic == 4'h6) ? {ve == 64'd0, ve[63], of} : cc;
        cz = cc[2]; cs = cc[1]; co = cc[0];
        cd = 1'b0;
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'd0: cd = 1'b1;
                4'd1: cd = (cs ^ co) | cz;
                4'd2: cd = cs ^ co;
                4'd3: cd = cz;
                4'd4: cd = !cz;
                4'd5: cd = !(cs ^ co);
                4'd6: cd = !(cs ^ co) && !cz;
                default: cd = 1'b0;
            endcase
        end
        case (ic)
            4'h2: de = cd ? rb : 4'hF;
            4'h3, 4'h6: de = rb;
            4'h8, 4'h9, 4'hA, 4'hB: de = 4'h4;
            default: de = 4'hF;
        endcase
        dm = (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'($urandom_range(0, 16));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [63:0] mvE, mvA, mvP, rve, vp;
        logic [3:0]  mi, mdE, mdM, rde, rdm;
        logic        mc, rcd;
        logic [2:0]  mcc, rccn;
        logic        rst_i, blk_i, stl_i, bub_i;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, va, vb;

        reset = 1'b1; e_icode = 4'h1; e_ifun = 4'h0; e_regA = 4'hF; e_regB = 4'hF;
        e_valC = '0; e_valP = '0; e_valA = '0; e_valB = '0;
        cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;

        //                  rst blk stl bub  ic    fn    ra    rb    valC    valA                   valB     | icode cnd valE                    valA                   dstE  dstM  cc
        tbl.push_back(mk(1, 0, 0, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,  64'h0,                 64'h0,   4'h1, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h6, 4'h0, 4'h5, 4'h3, 64'h0,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h6, 0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 4'hF, 3'b011));
        tbl.push_back(mk(0, 0, 0, 0, 4'h6, 4'h1, 4'h1, 4'h7, 64'h0,  64'h5,                 64'h5,   4'h6, 0, 64'h0,                  64'h5,                 4'h7, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h2, 4'h4, 4'h1, 4'h2, 64'h0,  64'h55,                64'h99,  4'h2, 0, 64'h55,                 64'h55,                4'hF, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0,  64'h77,                64'h100, 4'hA, 0, 64'hF8,                 64'h77,                4'h4, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'hB, 4'h0, 4'h1, 4'hF, 64'h0,  64'h108,               64'hF8,  4'hB, 0, 64'h100,                64'h108,               4'h4, 4'h1, 3'b100));
        tbl.push_back(mk(0, 1, 0, 0, 4'h6, 4'h3, 4'h1, 4'h6, 64'h0,  64'hF0,                64'h0F,  4'h6, 0, 64'hFF,                 64'hF0,                4'h6, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 1, 1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h2A, 64'h0,                 64'h0,   4'h1, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h2, 4'h0, 4'h1, 4'h9, 64'h0,  64'h1234,              64'h0,   4'h2, 1, 64'h1234,               64'h1234,              4'h9, 4'hF, 3'b100));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 1, 0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h2A, 64'h0,             64'h0,   4'h2, 1, 64'h1234,               64'h1234,              4'h9, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h2A, 64'h0,                 64'h0,   4'h3, 0, 64'h2A,                 64'h0,                 4'h2, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h6, 4'h1, 4'h1, 4'h8, 64'h0,  64'h5,                 64'h3,   4'h6, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5,                 4'h8, 4'hF, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 4'h7, 4'h2, 4'hF, 4'hF, 64'h40, 64'h0,                 64'h0,   4'h7, 1, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 4'hC, 4'h0, 4'h2, 4'h3, 64'h33, 64'h11,                64'h22,  4'hC, 0, 64'h0,                  64'h11,                4'hF, 4'hF, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 4'h7, 4'h6, 4'hF, 4'hF, 64'h40, 64'h0,                 64'h0,   4'h7, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b010));
        tbl.push_back(mk(0, 0, 1, 0, 4'h6, 4'h2, 4'h1, 4'h1, 64'h0,  64'h0,                 64'hFF,  4'h7, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h2, 4'h3, 4'h4, 4'h5, 64'h0,  64'h9,                 64'h0,   4'h2, 1, 64'h9,                  64'h9,                 4'h5, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h7, 4'h7, 4'hF, 4'hF, 64'h40, 64'h0,                 64'h0,   4'h7, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 4'h5, 4'h0, 4'h3, 4'h1, 64'h10, 64'h0,                 64'h20,  4'h5, 0, 64'h30,                 64'h0,                 4'hF, 4'h3, 3'b100));

        // Directed table
        foreach (tbl[i]) begin
            reset = tbl[i].rst; cc_block = tbl[i].blk; m_stall = tbl[i].stall; m_bubble = tbl[i].bub;
            e_icode = tbl[i].ic; e_ifun = tbl[i].fn; e_regA = tbl[i].ra; e_regB = tbl[i].rb;
            e_valC = tbl[i].vc; e_valA = tbl[i].va; e_valB = tbl[i].vb; e_valP = 64'h1000 + 64'(i);
            @(posedge clock); #1;
            check($sformatf("tbl[%0d]", i),
                  {64'h0, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, cc_out},
                  {64'h0, tbl[i].x_ic, tbl[i].x_cnd, tbl[i].x_ve, tbl[i].x_va, tbl[i].x_de, tbl[i].x_dm, tbl[i].x_cc});
        end

        // Randomized run against the reference model; first cycle resets
        mi = 4'h1; mc = 1'b0; mvE = '0; mvA = '0; mvP = '0; mdE = 4'hF; mdM = 4'hF; mcc = 3'b100;
        for (int n = 0; n < 400; n++) begin
            rst_i = (n == 0) || ($urandom_range(0, 63) == 0);
            blk_i = ($urandom_range(0, 7) == 0);
            stl_i = ($urandom_range(0, 7) == 0);
            bub_i = ($urandom_range(0, 15) == 0);
            ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ic = 4'h6;
            fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
            ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
            vc = rnd64(); va = rnd64(); vb = rnd64(); vp = {$urandom(), $urandom()};

            reset = rst_i; cc_block = blk_i; m_stall = stl_i; m_bubble = bub_i;
            e_icode = ic; e_ifun = fn; e_regA = ra; e_regB = rb;
            e_valC = vc; e_valA = va; e_valB = vb; e_valP = vp;
            ref_exec(ic, fn, ra, rb, vc, va, vb, mcc, rve, rcd, rde, rdm, rccn);

            if (rst_i || bub_i) begin
                mi = 4'h1; mc = 1'b0; mvE = '0; mvA = '0; mvP = '0; mdE = 4'hF; mdM = 4'hF;
            end else if (!stl_i) begin
                mi = ic; mc = rcd; mvE = rve; mvA = va; mvP = vp; mdE = rde; mdM = rdm;
            end
            if (rst_i) mcc = 3'b100;
            else if (!blk_i) mcc = rccn;

            @(posedge clock); #1;
            check($sformatf("rnd[%0d] ic=%h fn=%h", n, ic, fn),
                  {m_valP, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, cc_out},
                  {mvP, mi, mc, mvE, mvA, mdE, mdM, mcc});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
